// File: rtl/prescaled_mode_counter_if.sv
// Control/status bundle for prescaled_mode_counter: counter controls in, count/tc/dir out.
// The master drives the controls and the slave (the counter) drives the status.
interface prescaled_mode_counter_if #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
);
  logic             en;
  logic [1:0]       mode;
  logic             load;
  logic [WIDTH-1:0] load_val;
  logic [WIDTH-1:0] limit;
  logic [PRE_W-1:0] prescale;
  logic [WIDTH-1:0] count;
  logic             tc;
  logic             dir;

  modport master (
    output en, mode, load, load_val, limit, prescale,
    input  count, tc, dir
  );

  modport slave (
    input  en, mode, load, load_val, limit, prescale,
    output count, tc, dir
  );
endinterface

// File: rtl/prescaled_mode_counter.sv
// Up/down/bounce counter over 0..limit, advanced by an enable-gated prescaler tick.
// count/tc/dir update one edge after the tick; load overrides counting; no backpressure.
module prescaled_mode_counter #(
  parameter int WIDTH = 8,
  parameter int PRE_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  prescaled_mode_counter_if.slave bus
);

  typedef enum logic [1:0] {
    MODE_UP     = 2'b00,
    MODE_DOWN   = 2'b01,
    MODE_BOUNCE = 2'b10,
    MODE_HOLD   = 2'b11
  } mode_e;

  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             tick;
  mode_e            mode;

  assign mode = mode_e'(bus.mode);

  always_comb begin
    tick      = bus.en && (pre_cnt_q == bus.prescale);
    pre_cnt_d = pre_cnt_q;
    count_d   = count_q;
    dir_d     = dir_q;
    tc_d      = 1'b0;

    if (bus.load) begin
      pre_cnt_d = '0;
      count_d   = (bus.load_val > bus.limit) ? bus.limit : bus.load_val;
      dir_d     = (mode != MODE_DOWN);
    end else if (bus.en) begin
      // A prescale lowered below pre_cnt lets pre_cnt run on and wrap to 0 without a tick.
      pre_cnt_d = tick ? '0 : pre_cnt_q + PRE_W'(1);
      case (mode)
        MODE_UP: begin
          dir_d = 1'b1;
          if (tick) begin
            if (count_q >= bus.limit) begin
              count_d = '0;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q + WIDTH'(1);
            end
          end
        end
        MODE_DOWN: begin
          dir_d = 1'b0;
          if (tick) begin
            if (count_q == '0) begin
              count_d = bus.limit;
              tc_d    = 1'b1;
            end else begin
              count_d = count_q - WIDTH'(1);
            end
          end
        end
        MODE_BOUNCE: begin
          if (tick) begin
            if (dir_q) begin
              if (count_q >= bus.limit) begin
                dir_d   = 1'b0;
                count_d = (bus.limit == '0) ? '0 : bus.limit - WIDTH'(1);
                tc_d    = 1'b1;
              end else begin
                count_d = count_q + WIDTH'(1);
              end
            end else begin
              if (count_q == '0) begin
                dir_d   = 1'b1;
                count_d = (bus.limit == '0) ? '0 : WIDTH'(1);
                tc_d    = 1'b1;
              end else begin
                count_d = count_q - WIDTH'(1);
              end
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q <= '0;
      count_q   <= '0;
      dir_q     <= 1'b1;
      tc_q      <= 1'b0;
    end else begin
      pre_cnt_q <= pre_cnt_d;
      count_q   <= count_d;
      dir_q     <= dir_d;
      tc_q      <= tc_d;
    end
  end

  assign bus.count = count_q;
  assign bus.tc    = tc_q;
  assign bus.dir   = dir_q;

endmodule

// File: tb/tb_prescaled_mode_counter.sv
// Directed bench for prescaled_mode_counter with hand-computed expected sequences.
module tb_prescaled_mode_counter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  prescaled_mode_counter_if #(.WIDTH(8), .PRE_W(4)) cif ();

  prescaled_mode_counter #(.WIDTH(8), .PRE_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (cif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  logic [7:0] bnc_cnt [7];
  logic       bnc_tc  [7];
  logic       bnc_dir [7];

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst          = 1'b1;
    cif.en       = 1'b0;
    cif.mode     = 2'b00;
    cif.load     = 1'b0;
    cif.load_val = 8'd0;
    cif.limit    = 8'd0;
    cif.prescale = 4'd0;
    #2;
    check("rst_count", cif.count, 0);
    check("rst_dir", cif.dir, 1);
    check("rst_tc", cif.tc, 0);
    step();
    check("rst_pre", dut.pre_cnt_q, 0);

    // Mode up, limit 5, every cycle a tick.
    cif.mode = 2'b00; cif.limit = 8'd5; cif.prescale = 4'd0; cif.en = 1'b1;
    rst = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      step();
      check($sformatf("up_count%0d", i), cif.count, i % 6);
      check($sformatf("up_tc%0d", i), cif.tc, (i == 6) ? 1 : 0);
    end

    // Mode down, limit 3, prescale 2.
    cif.en = 1'b0;
    do_reset();
    cif.mode = 2'b01; cif.limit = 8'd3; cif.prescale = 4'd2; cif.en = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      check($sformatf("dn_count%0d", k), cif.count, (k < 3) ? 0 : 4 - k / 3);
      check($sformatf("dn_tc%0d", k), cif.tc, (k == 3) ? 1 : 0);
    end
    check("dn_dir", cif.dir, 0);

    // Bounce, limit 3, prescale 0.
    bnc_cnt = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1};
    bnc_tc  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    bnc_dir = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    cif.en = 1'b0;
    do_reset();
    cif.mode = 2'b10; cif.limit = 8'd3; cif.prescale = 4'd0; cif.en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("bnc_count%0d", i), cif.count, bnc_cnt[i]);
      check($sformatf("bnc_tc%0d", i), cif.tc, bnc_tc[i]);
      check($sformatf("bnc_dir%0d", i), cif.dir, bnc_dir[i]);
    end

    // Load clamps to limit and beats a same-cycle tick.
    cif.en = 1'b0; cif.mode = 2'b00; cif.limit = 8'd100;
    cif.load = 1'b1; cif.load_val = 8'd200;
    step();
    check("ld_clamp", cif.count, 100);
    check("ld_pre", dut.pre_cnt_q, 0);
    check("ld_tc", cif.tc, 0);
    check("ld_dir", cif.dir, 1);
    cif.en = 1'b1; cif.prescale = 4'd0; cif.load_val = 8'd50;
    step();
    check("ld_tick_count", cif.count, 50);
    check("ld_tick_tc", cif.tc, 0);
    cif.load_val = 8'd100;
    step();
    check("ld_top_count", cif.count, 100);
    check("ld_top_tc", cif.tc, 0);
    cif.load = 1'b0;
    step();
    check("wrap_count", cif.count, 0);
    check("wrap_tc", cif.tc, 1);
    cif.mode = 2'b01; cif.load = 1'b1; cif.load_val = 8'd5;
    step();
    check("ld_dn_count", cif.count, 5);
    check("ld_dn_dir", cif.dir, 0);

    // Limit lowered below count.
    cif.en = 1'b0; cif.mode = 2'b00; cif.limit = 8'd10; cif.load_val = 8'd7;
    step();
    cif.load = 1'b0; cif.limit = 8'd4; cif.en = 1'b1;
    step();
    check("lim_up_count", cif.count, 0);
    check("lim_up_tc", cif.tc, 1);
    cif.en = 1'b0; cif.load = 1'b1; cif.limit = 8'd10; cif.mode = 2'b01;
    step();
    cif.load = 1'b0; cif.limit = 8'd4; cif.en = 1'b1;
    step();
    check("lim_dn_count", cif.count, 6);
    check("lim_dn_tc", cif.tc, 0);

    // Hold mode keeps count while the prescaler runs; en=0 freezes everything.
    cif.mode = 2'b11; cif.prescale = 4'd7;
    cif.load = 1'b1; cif.load_val = 8'd3;
    step();
    cif.load = 1'b0;
    for (int i = 0; i < 9; i++) step();
    check("hold_count", cif.count, 3);
    check("hold_tc", cif.tc, 0);
    check("hold_pre", dut.pre_cnt_q, 1);
    cif.en = 1'b0; cif.mode = 2'b00;
    for (int i = 0; i < 4; i++) step();
    check("en0_pre", dut.pre_cnt_q, 1);
    check("en0_count", cif.count, 3);

    // Async reset between edges at count 9 with dir=0 and tc high.
    cif.mode = 2'b01; cif.limit = 8'd9; cif.load = 1'b1; cif.load_val = 8'd0;
    step();
    cif.load = 1'b0; cif.prescale = 4'd0; cif.en = 1'b1;
    step();
    check("pre_rst_count", cif.count, 9);
    check("pre_rst_tc", cif.tc, 1);
    cif.en = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("arst_count", cif.count, 0);
    check("arst_dir", cif.dir, 1);
    check("arst_tc", cif.tc, 0);
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) step();
    check("post_rst_count", cif.count, 0);

    // Reset discards prescaler progress.
    cif.mode = 2'b00; cif.limit = 8'd10; cif.prescale = 4'd3; cif.en = 1'b1;
    step(); step();
    check("prog_pre", dut.pre_cnt_q, 2);
    do_reset();
    step(); step(); step();
    check("prog_count3", cif.count, 0);
    step();
    check("prog_count4", cif.count, 1);

    // Prescale lowered under pre_cnt: wrap through all-ones with no tick.
    cif.en = 1'b0;
    do_reset();
    cif.limit = 8'd100; cif.prescale = 4'd5; cif.en = 1'b1;
    for (int i = 0; i < 4; i++) step();
    check("pw_pre", dut.pre_cnt_q, 4);
    cif.prescale = 4'd2;
    for (int i = 0; i < 14; i++) step();
    check("pw_count", cif.count, 0);
    check("pw_pre0", dut.pre_cnt_q, 2);
    step();
    check("pw_tick", cif.count, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prescaled_mode_counter.md
PRESCALED_MODE_COUNTER -- requirements
Module: prescaled_mode_counter

Interface
REQ-001 Parameter WIDTH, default 8, counter width in bits (SHALL be 2..32).
REQ-002 Parameter PRE_W, default 4, prescaler width in bits (SHALL be 1..16).
REQ-003 clk  input  1  single clock; all state SHALL update on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; gates prescaler advance.
REQ-006 mode  input  2  00 up, 01 down, 10 bounce (up/down), 11 hold.
REQ-007 load  input  1  synchronous load strobe.
REQ-008 load_val  input  WIDTH  value loaded on load.
REQ-009 limit  input  WIDTH  terminal/top value of count range 0..limit.
REQ-010 prescale  input  PRE_W  divide ratio minus one; a tick SHALL occur every prescale+1 enabled cycles.
REQ-011 count  output  WIDTH  current counter value, registered.
REQ-012 tc  output  1  terminal-count pulse, registered, one cycle wide.
REQ-013 dir  output  1  current direction, 1 = up, 0 = down, registered.

Function
REQ-014 Prescaler pre_cnt (PRE_W bits) SHALL advance only when en=1; tick SHALL assert combinationally when en=1 and pre_cnt==prescale, and pre_cnt SHALL return to 0 on that cycle.
REQ-015 With en=0, pre_cnt, count, dir SHALL hold and tc SHALL be 0.
REQ-016 prescale=0 SHALL give a tick on every en=1 cycle; a prescale change while pre_cnt>prescale SHALL cause pre_cnt to wrap past all-ones to 0 without a tick at that wrap.
REQ-017 load SHALL have priority over all counting: count<=min(load_val, limit), pre_cnt<=0, tc<=0, independent of en; dir<=1 in modes 00/10/11, 0 in mode 01.
REQ-018 Mode 00 on tick: count>=limit -> count<=0, tc<=1; else count<=count+1.
REQ-019 Mode 01 on tick: count==0 -> count<=limit, tc<=1; else count<=count-1 (a count above limit SHALL decrement normally).
REQ-020 Mode 10 on tick, dir=1: count>=limit -> dir<=0, count<=limit-1 (0 if limit==0), tc<=1; else count<=count+1.
REQ-021 Mode 10 on tick, dir=0: count==0 -> dir<=1, count<=1 (0 if limit==0), tc<=1; else count<=count-1.
REQ-022 Mode 10 with limit=3 from count=0 SHALL produce 0,1,2,3,2,1,0,1,... with tc on the ticks producing 2 (from 3) and 1 (from 0).
REQ-023 Mode 11: count and dir hold, prescaler keeps running, tc=0.
REQ-024 In modes 00/01, dir SHALL follow mode (1/0) every cycle; entering mode 10 SHALL keep the current dir.
REQ-025 tc SHALL be 0 on every cycle not described as tc<=1 above; tc and the corresponding count update SHALL appear on the same clock edge (latency 1 from tick).
REQ-026 Mode, limit and prescale changes SHALL take effect on the next clock edge; no other pipeline delay.
REQ-027 All arithmetic SHALL be WIDTH bits modulo 2^WIDTH; count SHALL never exceed limit except when limit is lowered below the current count (then REQ-018..021 apply).

Reset
REQ-028 While rst=1: count=0, pre_cnt=0, dir=1, tc=0, asynchronously, regardless of clk.
REQ-029 Reset asserted mid-count SHALL discard prescaler progress; first tick after release SHALL come prescale+1 enabled cycles later.
REQ-030 After rst deasserts, first state change SHALL occur on the first rising clk edge with rst=0.

Verification
REQ-031 Mode 00, limit=5, prescale=0, en=1 -> count 0,1,2,3,4,5,0; tc high exactly on the cycle count returns to 0.
REQ-032 Mode 01, limit=3, prescale=2, en=1 from reset -> count 0 for 3 cycles, then 3 with tc, then 2,1,0 every 3 cycles.
REQ-033 Mode 10, limit=3, prescale=0 -> 0,1,2,3,2,1,0,1; dir falls with count 3->2, rises with 0->1; tc on both turnarounds.
REQ-034 load=1 with load_val=200, limit=100, en=0 -> count=100, pre_cnt=0, tc=0 next cycle; load and tick same cycle -> load wins.
REQ-035 Mode 00, count=7, limit lowered to 4 -> next tick count=0 with tc=1.
REQ-036 rst pulsed between clock edges at count=9 -> count=0, dir=1, tc=0 immediately; en=0 for 10 cycles after -> count stays 0.
